pulse_detection_mc: RTL and testbench

PULSE_DETECTION_MC -- requirements
Module: pulse_detection_mc

---
 rtl/pulse_detection_mc_if.sv | 23 ++
 rtl/pulse_detection_mc.sv | 107 ++++++++++
 tb/tb_pulse_detection_mc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_detection_mc_if.sv
// Bus bundle for the multi-channel pulse detector: raw inputs and clears in,
// debounced level plus edge/event/glitch indications out.
interface pulse_detection_mc_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] d;
  logic [CHANNELS-1:0] event_clr;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] level;
  // `event` is a reserved word, so the sticky flag is carried as event_flag.
  logic [CHANNELS-1:0] event_flag;
  logic [CHANNELS-1:0] glitch;

  modport master (
    output d, event_clr,
    input  q, level, event_flag, glitch
  );

  modport slave (
    input  d, event_clr,
    output q, level, event_flag, glitch
  );
endinterface

// File: rtl/pulse_detection_mc.sv
// Multi-channel debounced edge detector: per-channel synchronizer, stability
// filter, edge pulse, sticky event flag and rejected-change glitch pulse.
module pulse_detection_lane #(
  parameter int FILTER_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_MODE     = 0,
  parameter bit RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic event_clr,
  output logic q,
  output logic level,
  output logic event_flag,
  output logic glitch
);
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic level_q, level_d;
  logic q_q, q_d;
  logic event_q, event_d;
  logic glitch_q, glitch_d;
  logic s, differ, accept, edge_ok;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], d};
    s        = sync_q[SYNC_STAGES-1];
    differ   = (s != level_q);
    accept   = differ && (cnt_q == CNT_LAST);
    if (EDGE_MODE == 0)      edge_ok = ~s;
    else if (EDGE_MODE == 1) edge_ok = s;
    else                     edge_ok = 1'b1;
    // cnt only survives while the sample keeps disagreeing with level
    cnt_d    = '0;
    level_d  = level_q;
    if (accept)      level_d = s;
    else if (differ) cnt_d   = cnt_q + 1'b1;
    q_d      = accept && edge_ok;
    glitch_d = !differ && (cnt_q != '0);
    // a new pulse outranks a simultaneous clear
    event_d  = q_q | (event_q & ~event_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      q_q      <= 1'b0;
      event_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      q_q      <= q_d;
      event_q  <= event_d;
      glitch_q <= glitch_d;
    end
  end

  assign q          = q_q;
  assign level      = level_q;
  assign event_flag = event_q;
  assign glitch     = glitch_q;
endmodule

module pulse_detection_mc #(
  parameter int CHANNELS      = 4,
  parameter int FILTER_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_MODE     = 0,
  parameter bit RESET_LEVEL   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  pulse_detection_mc_if.slave bus
);
  logic [CHANNELS-1:0] q_w, level_w, event_w, glitch_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pulse_detection_lane #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .EDGE_MODE     (EDGE_MODE),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .d          (bus.d[c]),
      .event_clr  (bus.event_clr[c]),
      .q          (q_w[c]),
      .level      (level_w[c]),
      .event_flag (event_w[c]),
      .glitch     (glitch_w[c])
    );
  end

  assign bus.q          = q_w;
  assign bus.level      = level_w;
  assign bus.event_flag = event_w;
  assign bus.glitch     = glitch_w;
endmodule

// File: tb/tb_pulse_detection_mc.sv
// Bench for pulse_detection_mc: two instances (falling-only and both-edge modes)
// share stimulus and are compared every cycle against a sample-window model.
module tb_pulse_detection_mc;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam int F  = 8;
  localparam int DEPTH = S + F;

  logic clk = 1'b0;
  logic reset;
  logic [CH-1:0] d_drv, clr_drv;

  always #5 clk = ~clk;

  pulse_detection_mc_if #(.CHANNELS(CH)) bus0 ();
  pulse_detection_mc_if #(.CHANNELS(CH)) bus2 ();

  assign bus0.d = d_drv;
  assign bus0.event_clr = clr_drv;
  assign bus2.d = d_drv;
  assign bus2.event_clr = clr_drv;

  pulse_detection_mc #(.CHANNELS(CH), .FILTER_CYCLES(F), .SYNC_STAGES(S),
                       .EDGE_MODE(0), .RESET_LEVEL(1'b1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  pulse_detection_mc #(.CHANNELS(CH), .FILTER_CYCLES(F), .SYNC_STAGES(S),
                       .EDGE_MODE(2), .RESET_LEVEL(1'b1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  // Model: hist[c][0] is the raw d taken at the latest edge; the synchronized
  // sample seen at that edge is hist[c][S], and the last F seen samples are
  // hist[c][S .. S+F-1]. Level flips when all F of them disagree with it.
  logic hist [CH][DEPTH];
  logic [CH-1:0] m_lvl, m_gl, m_q0, m_q2, m_ev0, m_ev2;

  int n_assert = 0;
  int n_fail   = 0;
  int gl_cnt, q0_cnt, q2_cnt, low_cnt;
  int run_len [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < DEPTH; i++) hist[c][i] = 1'b1;
    m_lvl = '1;
    m_gl  = '0;
    m_q0  = '0;
    m_q2  = '0;
    m_ev0 = '0;
    m_ev2 = '0;
  endtask

  task automatic model_edge(input logic [CH-1:0] dv, input logic [CH-1:0] cv);
    logic [CH-1:0] pq0, pq2;
    logic all_diff;
    pq0 = m_q0;
    pq2 = m_q2;
    for (int c = 0; c < CH; c++) begin
      for (int i = DEPTH - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = dv[c];
      all_diff = 1'b1;
      for (int i = S; i < S + F; i++)
        if (hist[c][i] == m_lvl[c]) all_diff = 1'b0;
      m_gl[c]  = (hist[c][S] == m_lvl[c]) && (hist[c][S+1] != m_lvl[c]);
      m_ev0[c] = pq0[c] | (m_ev0[c] & ~cv[c]);
      m_ev2[c] = pq2[c] | (m_ev2[c] & ~cv[c]);
      m_q2[c]  = all_diff;
      m_q0[c]  = all_diff && m_lvl[c];
      if (all_diff) m_lvl[c] = ~m_lvl[c];
    end
  endtask

  task automatic check_all();
    chk("level_m0",  bus0.level,      m_lvl);
    chk("q_m0",      bus0.q,          m_q0);
    chk("event_m0",  bus0.event_flag, m_ev0);
    chk("glitch_m0", bus0.glitch,     m_gl);
    chk("level_m2",  bus2.level,      m_lvl);
    chk("q_m2",      bus2.q,          m_q2);
    chk("event_m2",  bus2.event_flag, m_ev2);
    chk("glitch_m2", bus2.glitch,     m_gl);
  endtask

  // One clock: inputs as they stand before the edge feed the model, outputs
  // are checked 1 ns after the edge.
  task automatic tick();
    logic [CH-1:0] dv, cv;
    logic rv;
    dv = d_drv;
    cv = clr_drv;
    rv = reset;
    @(posedge clk);
    if (rv) model_reset();
    else    model_edge(dv, cv);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    d_drv   = '1;
    clr_drv = '0;
    model_reset();
    #1;
    chk("rst_level", bus0.level, 4'hF);
    chk("rst_q",     bus0.q, 4'h0);
    chk("rst_event", bus2.event_flag, 4'h0);
    chk("rst_glitch", bus2.glitch, 4'h0);
    tick();
    tick();
    #3 reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Falling edge on ch0: sampled at edge 1, level/q at edge 10, event from 11.
    d_drv[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("ch0_fall_q",     bus0.q[0], k == 10);
      chk("ch0_fall_level", bus0.level[0], k < 10);
      chk("ch0_fall_event", bus0.event_flag[0], k >= 11);
      chk("others_quiet",   bus0.q[3:1], 3'b000);
    end

    // Clear, rise (no falling pulse), then fall with clear coinciding with q.
    clr_drv[0] = 1'b1;
    tick();
    clr_drv[0] = 1'b0;
    chk("ch0_evt_cleared", bus0.event_flag[0], 1'b0);
    d_drv[0] = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    chk("ch0_rise_no_event_m0", bus0.event_flag[0], 1'b0);
    d_drv[0] = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("ch0_q_again", bus0.q[0], 1'b1);
    clr_drv[0] = 1'b1;
    tick();
    clr_drv[0] = 1'b0;
    chk("ch0_set_wins", bus0.event_flag[0], 1'b1);
    tick();
    tick();
    chk("ch0_evt_held", bus0.event_flag[0], 1'b1);
    clr_drv[0] = 1'b1;
    tick();
    clr_drv[0] = 1'b0;
    chk("ch0_clr_alone", bus0.event_flag[0], 1'b0);

    // ch1 low pulses of 3, 7 and 8 cycles.
    for (int p = 0; p < 3; p++) begin
      int len;
      len = (p == 0) ? 3 : (p == 1) ? 7 : 8;
      gl_cnt = 0; q0_cnt = 0; q2_cnt = 0; low_cnt = 0;
      d_drv[1] = 1'b0;
      for (int k = 0; k < len + 25; k++) begin
        if (k == len) d_drv[1] = 1'b1;
        tick();
        gl_cnt  += int'(bus0.glitch[1]);
        q0_cnt  += int'(bus0.q[1]);
        q2_cnt  += int'(bus2.q[1]);
        low_cnt += int'(!bus0.level[1]);
      end
      if (len < F) begin
        chk("ch1_short_glitches", gl_cnt, 1);
        chk("ch1_short_q",        q0_cnt + q2_cnt, 0);
        chk("ch1_short_level",    low_cnt, 0);
      end else begin
        chk("ch1_full_glitches", gl_cnt, 0);
        chk("ch1_full_q_m0",     q0_cnt, 1);
        chk("ch1_full_q_m2",     q2_cnt, 2);
      end
    end

    // ch2 fall then rise: falling-only mode pulses once, both-edge mode twice.
    q0_cnt = 0; q2_cnt = 0;
    d_drv[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      q0_cnt += int'(bus0.q[2]);
      q2_cnt += int'(bus2.q[2]);
    end
    d_drv[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("ch2_rise_level", bus0.level[2], k >= 10);
      q0_cnt += int'(bus0.q[2]);
      q2_cnt += int'(bus2.q[2]);
    end
    chk("ch2_q_m0", q0_cnt, 1);
    chk("ch2_q_m2", q2_cnt, 2);

    // Reset with ch0 mid-filter (cnt = 5), then release with d still low.
    d_drv[0] = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    d_drv[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_level",  bus0.level, 4'hF);
    chk("async_rst_event",  bus2.event_flag, 4'h0);
    chk("async_rst_q",      bus2.q, 4'h0);
    chk("async_rst_glitch", bus0.glitch, 4'h0);
    tick();
    tick();
    #3 reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("post_rst_q",      bus0.q[0], k == 10);
      chk("post_rst_glitch", bus0.glitch[0], 1'b0);
    end

    // All channels concurrently with random run lengths and random clears.
    for (int c = 0; c < CH; c++) run_len[c] = $urandom_range(1, 14);
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++) begin
        run_len[c]--;
        if (run_len[c] <= 0) begin
          d_drv[c]   = ~d_drv[c];
          run_len[c] = $urandom_range(1, 14);
        end
        clr_drv[c] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    clr_drv = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
